mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory stage of the RV32I pipeline. It consumes the execute-stage bundle (ALU result/address, store data, rd, mem/wb/ld control) and, for loads and stores, runs a req/ack transaction to data memory with byte-lane steering. It then presents an aligned, sign/zero-extended writeback bundle to the WB stage and stalls upstream while a memory access is outstanding.

Parameters:
TIMEOUT_CYC, 255, number of WAIT cycles without dmem_ack before the access is aborted (8-bit counter).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute bundle valid this cycle
alu_result  in  32  ALU result, or effective address for ld/st
store_data  in  32  rs2 value for stores
rd_in  in  5  destination register
func3  in  3  width/sign select (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010)
mem_enable, mem_read, mem_write, wb_enable, ld  in  1 each  execute control bits
stall_out  out  1  upstream must hold its bundle
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, bits [1:0] = 0
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  request completed; rdata valid same cycle
dmem_rdata  in  32  read word
wb_valid, wb_rd[5], wb_data[32], wb_enable_out, ld_wb  out  writeback bundle
bus_err  out  1  one-cycle pulse on timeout
misalign  out  1  one-cycle pulse on misaligned access

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; timeout counter 0. Reset during WAIT drops dmem_req immediately and abandons the access. Nothing is written back.
- FSM states: IDLE, WAIT.
- IDLE, ex_valid=1, non-memory: applies when mem_enable=0, or mem_enable=1 with mem_read=mem_write=0. Next cycle wb_valid=1, wb_data=alu_result, wb_rd/wb_enable_out/ld_wb follow the inputs. Latency is 1 cycle.
- IDLE, ex_valid=1, memory: registers the bundle. Next cycle enters WAIT with dmem_req=1, dmem_addr={alu_result[31:2],2'b00}, and dmem_we=mem_write.
- If mem_read and mem_write are both 1, the access is treated as a store and wb_enable_out is forced to 0.
- WAIT:
  - dmem_req, addr, we, be and wdata stay stable until ack.
  - stall_out=1 for every WAIT cycle, including the ack cycle. ex_valid is ignored in WAIT.
  - Counter increments each cycle without ack.
- On ack: load data is extracted by func3 and addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, any other func3 is treated as LW. The next cycle gives wb_valid=1 with the result, and the FSM returns to IDLE. Stores give wb_valid=1 with wb_enable_out=0.
- Timeout: when the counter reaches TIMEOUT_CYC with no ack, dmem_req drops and bus_err pulses. The next cycle gives wb_valid=1 with wb_enable_out=0, then IDLE.
- Store steering:
  - SB: be=4'b0001<<addr[1:0]; the byte is replicated ×4.
  - SH: be=4'b0011 if addr[1]=0, else 4'b1100; the halfword is replicated ×2.
  - SW: be=4'b1111.
  - Loads drive be=4'b1111.
- wb_valid is a single-cycle pulse per accepted instruction. The stage accepts at most one instruction per cycle. Back-to-back non-memory instructions sustain 1/cycle.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, issues no bus request. misalign pulses with the writeback cycle, wb_valid=1 and wb_enable_out=0, with 1-cycle latency.
- Undefined: low address bits are ignored for half/word accesses (H uses addr[1], W uses lane 0), and misalign is tied 0.

Decomposition:
- Package rv32_mem_pkg: func3 constants (F3_LB…F3_LHU, F3_SB/SH/SW), state enum {IDLE,WAIT}, TIMEOUT_CYC default.
- One combinational sub-module, lsu_lane_align. It takes func3, addr[1:0], store_data and rdata, and returns be, wdata and the extended load data.

Test Plan:
- Non-memory ALU op: alu_result=32'h0000_0042, rd=5, wb_enable=1 → next cycle wb_valid=1, wb_data=42, wb_rd=5; stall_out stays 0.
- LB with addr=32'h1003 and rdata=32'h80FF_0000, ack after 3 cycles → dmem_addr=32'h1000, stall_out high for 3 cycles, wb_data=32'hFFFF_FF80.
- LHU with addr=32'h2002 and rdata=32'h8001_1234 → wb_data=32'h0000_8001.
- SB of store_data=32'h0000_00AB at addr 32'h3001 → be=4'b0010, wdata=32'hABAB_ABAB, wb_enable_out=0.
- Store with ack withheld and TIMEOUT_CYC=4 → req held for 4 WAIT cycles, then bus_err pulse, dmem_req=0, wb_valid with wb_enable_out=0.
- rst_n low during WAIT → dmem_req=0 immediately, no wb_valid. With MISALIGN_TRAP_EN, LW at 32'h4002 → no req, misalign=1 one cycle later.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I memory-access stage: func3 encodings,
// FSM states, access-size decode helpers and the default timeout.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Unlisted load encodings behave as LW.
  function automatic size_t load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      F3_LW:         return SZ_W;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic size_t store_size(input logic [2:0] f3);
    case (f3)
      F3_SB:   return SZ_B;
      F3_SH:   return SZ_H;
      F3_SW:   return SZ_W;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_H:    return a[0];
      SZ_W:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// extraction plus sign/zero extension of load data from the read word.
module lsu_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    be    = 4'b1111;
    wdata = store_data;
    case (store_size(func3))
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // func3[2] set selects the unsigned (zero-extending) load variants.
  always_comb begin
    ld_byte   = 8'(rdata >> {addr_lo, 3'b000});
    ld_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (load_size(func3))
      SZ_B:    load_data = func3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    load_data = func3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory stage: req/ack data-memory transaction with timeout and
// writeback bundle. Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module mem_access_stage
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  func3,
  input  logic        mem_enable,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_enable,
  input  logic        ld,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_enable_out,
  output logic        ld_wb,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, sdata_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q, wb_en_q, ld_q;

  logic        is_mem, trap, accept, start_mem, timed_out, acked;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign is_mem = mem_enable && (mem_read || mem_write);

`ifdef MISALIGN_TRAP_EN
  assign trap = is_mem && misaligned(mem_write ? store_size(func3) : load_size(func3),
                                     alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && ex_valid;
  assign start_mem = accept && is_mem && !trap;
  assign timed_out = (state_q == WAIT) && (cnt_q == TIMEOUT_CNT);
  assign acked     = (state_q == WAIT) && !timed_out && dmem_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mem) state_d = WAIT;
      WAIT:    if (acked || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_lane_align u_align (
    .func3      (f3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // Request side is decoded from state so reset drops it without waiting for a clock.
  assign stall_out  = (state_q == WAIT);
  assign dmem_req   = (state_q == WAIT) && !timed_out;
  assign bus_err    = timed_out;
  assign dmem_we    = dmem_req && we_q;
  assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign dmem_be    = dmem_req ? (we_q ? lane_be : 4'b1111) : 4'b0;
  assign dmem_wdata = dmem_we ? lane_wdata : 32'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      sdata_q       <= '0;
      f3_q          <= '0;
      rd_q          <= '0;
      we_q          <= 1'b0;
      wb_en_q       <= 1'b0;
      ld_q          <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_enable_out <= 1'b0;
      ld_wb         <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (start_mem) begin
        cnt_q   <= '0;
        addr_q  <= alu_result;
        sdata_q <= store_data;
        f3_q    <= func3;
        rd_q    <= rd_in;
        we_q    <= mem_write;
        wb_en_q <= wb_enable && !mem_write;
        ld_q    <= ld;
      end else if (accept) begin
        wb_valid      <= 1'b1;
        wb_rd         <= rd_in;
        wb_data       <= alu_result;
        wb_enable_out <= wb_enable && !trap;
        ld_wb         <= ld;
        misalign      <= trap;
      end else if (acked || timed_out) begin
        wb_valid      <= 1'b1;
        wb_rd         <= rd_q;
        wb_data       <= (we_q || timed_out) ? addr_q : lane_load;
        wb_enable_out <= wb_en_q && acked;
        ld_wb         <= ld_q;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a cycle-scheduled behavioural
// model plus one per-cycle compare process, directed cases and random traffic.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
  logic [4:0]  rd_in = '0;
  logic [2:0]  func3 = '0;
  logic        mem_enable = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        wb_enable = 1'b0, ld = 1'b0, dmem_ack = 1'b0;
  logic        stall_out, dmem_req, dmem_we, wb_valid, wb_enable_out, ld_wb, bus_err, misalign;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .rd_in(rd_in), .func3(func3), .mem_enable(mem_enable),
    .mem_read(mem_read), .mem_write(mem_write), .wb_enable(wb_enable), .ld(ld),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_enable_out(wb_enable_out),
    .ld_wb(ld_wb), .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        mem_enable, mem_read, mem_write, wb_enable, ld;
    logic [2:0]  func3;
    logic [31:0] alu, sdata;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    bit          stall, req, buserr, misal, wb, we, wben, ldwb, data_known;
    logic [31:0] addr, wdata, data;
    logic [3:0]  be;
    logic [4:0]  rd;
  } cyc_exp_t;

  cyc_exp_t sched [int];

  int n_cmp = 0, n_bad = 0;
  int stall_cnt = 0, req_cnt = 0, berr_cnt = 0, wb_cnt = 0, mis_cnt = 0;
  logic [31:0] last_wb_data = '0, last_addr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;
  logic        last_wben = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_bytes(input logic [2:0] f3, input bit st);
    if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [1:0] a, input bit st);
    return (int'(a) % m_bytes(f3, st)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    int b = m_bytes(f3, 1'b1);
    int off = int'(a) & ~(b - 1);
    return 4'(((1 << b) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int b = m_bytes(f3, 1'b1);
    if (b == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (b == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    int b = m_bytes(f3, 1'b0);
    int off = int'(a) & ~(b - 1);
    logic [31:0] mask, v;
    if (b == 4) return w;
    mask = (32'h1 << (8 * b)) - 32'h1;
    v = (w >> (8 * off)) & mask;
    if (!f3[2] && v[8*b-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic cyc_exp_t get_exp(input int c);
    cyc_exp_t z;
    z = '{default: 0};
    if (sched.exists(c)) z = sched[c];
    return z;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc_exp_t e;
    e = get_exp(cyc);
    check("stall_out", stall_out, e.stall);
    check("dmem_req", dmem_req, e.req);
    check("bus_err", bus_err, e.buserr);
    check("misalign", misalign, e.misal);
    check("wb_valid", wb_valid, e.wb);
    if (e.req) begin
      check("dmem_addr", dmem_addr, e.addr);
      check("dmem_we", dmem_we, e.we);
      check("dmem_be", dmem_be, e.be);
      if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
    end
    if (e.wb && wb_valid) begin
      check("wb_rd", wb_rd, e.rd);
      check("wb_enable_out", wb_enable_out, e.wben);
      check("ld_wb", ld_wb, e.ldwb);
      if (e.data_known) check("wb_data", wb_data, e.data);
    end
    if (stall_out) stall_cnt++;
    if (bus_err) berr_cnt++;
    if (misalign) mis_cnt++;
    if (dmem_req) begin
      req_cnt++; last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata;
    end
    if (wb_valid) begin
      wb_cnt++; last_wb_data = wb_data; last_wben = wb_enable_out;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t in, input logic v);
    ex_valid = v; alu_result = in.alu; store_data = in.sdata; rd_in = in.rd;
    func3 = in.func3; mem_enable = in.mem_enable; mem_read = in.mem_read;
    mem_write = in.mem_write; wb_enable = in.wb_enable; ld = in.ld;
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    logic [2:0] lf3 [6];
    int kind = $urandom_range(0, 3);
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    r.alu = $urandom; r.sdata = $urandom; r.rd = 5'($urandom);
    r.wb_enable = 1'($urandom); r.ld = 1'($urandom); r.func3 = 3'($urandom);
    r.mem_enable = 1'b1; r.mem_read = 1'b0; r.mem_write = 1'b0;
    case (kind)
      0: begin
        r.mem_enable = 1'($urandom);
        if (!r.mem_enable) begin r.mem_read = 1'($urandom); r.mem_write = 1'($urandom); end
      end
      1: begin r.mem_read = 1'b1; r.func3 = lf3[$urandom_range(0, 5)]; end
      2: begin r.mem_write = 1'b1; r.func3 = 3'($urandom_range(0, 2)); end
      default: begin r.mem_read = 1'b1; r.mem_write = 1'b1; r.func3 = 3'($urandom_range(0, 2)); end
    endcase
    return r;
  endfunction

  task automatic idle_cycle();
    drive(rand_instr(), 1'b0);
    next_cycle();
  endtask

  // delay = WAIT cycle on which ack arrives (1..TO); 0 withholds ack.
  task automatic run_instr(input instr_t in, input int delay, input logic [31:0] rdata);
    int c, n;
    cyc_exp_t e;
    bit is_mem, is_st, trap;
    logic [1:0] a;
    c = cyc;
    drive(in, 1'b1);
    a = in.alu[1:0];
    is_mem = in.mem_enable && (in.mem_read || in.mem_write);
    is_st = in.mem_write;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = is_mem && m_misaligned(in.func3, a, is_st);
`endif
    if (!is_mem || trap) begin
      e = get_exp(c + 1);
      e.wb = 1; e.rd = in.rd; e.wben = in.wb_enable && !trap; e.ldwb = in.ld;
      e.data_known = 1; e.data = in.alu; e.misal = trap;
      sched[c + 1] = e;
      next_cycle();
      return;
    end
    n = (delay == 0) ? TO : delay;
    for (int i = 1; i <= n; i++) begin
      e = get_exp(c + i);
      e.stall = 1; e.req = 1; e.addr = in.alu & ~32'h3; e.we = is_st;
      e.be = is_st ? m_be(in.func3, a) : 4'hF; e.wdata = m_wdata(in.func3, in.sdata);
      sched[c + i] = e;
    end
    if (delay == 0) begin
      e = get_exp(c + n + 1); e.stall = 1; e.buserr = 1; sched[c + n + 1] = e;
    end
    e = get_exp(c + n + 1 + (delay == 0 ? 1 : 0));
    e.wb = 1; e.rd = in.rd; e.ldwb = in.ld;
    e.wben = (delay != 0) && in.wb_enable && !is_st;
    e.data_known = (delay != 0) && !is_st;
    e.data = m_load(in.func3, a, rdata);
    sched[c + n + 1 + (delay == 0 ? 1 : 0)] = e;
    next_cycle();
    for (int i = 1; i <= n + (delay == 0 ? 1 : 0); i++) begin
      drive(rand_instr(), 1'($urandom));
      dmem_ack = (delay != 0) && (i == delay);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      next_cycle();
    end
    dmem_ack = 1'b0;
  endtask

  function automatic instr_t mk(input logic men, mrd, mwr, input logic [2:0] f3,
                                input logic [31:0] alu, sd, input logic [4:0] rd, input logic wbe);
    instr_t r;
    r.mem_enable = men; r.mem_read = mrd; r.mem_write = mwr; r.func3 = f3;
    r.alu = alu; r.sdata = sd; r.rd = rd; r.wb_enable = wbe; r.ld = mrd & ~mwr;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int s0, r0, b0, w0, m0;
    instr_t in;
    cyc_exp_t e;
    int c;

    #2;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_stall", stall_out, 0);
    check("rst_wb_data", wb_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    check("model_lb", m_load(3'b000, 2'd3, 32'h80FF_0000), 32'hFFFF_FF80);
    check("model_lhu", m_load(3'b101, 2'd2, 32'h8001_1234), 32'h0000_8001);
    check("model_sb_be", m_be(3'b000, 2'd1), 4'b0010);
    check("model_sh_wdata", m_wdata(3'b001, 32'h1234_5678), 32'h5678_5678);

    s0 = stall_cnt;
    run_instr(mk(0, 0, 0, 3'b000, 32'h42, 0, 5'd5, 1), 0, 0);
    idle_cycle();
    check("alu_wb_data", last_wb_data, 32'h42);
    check("alu_no_stall", stall_cnt - s0, 0);

    s0 = stall_cnt;
    run_instr(mk(1, 1, 0, 3'b000, 32'h1003, 0, 5'd7, 1), 3, 32'h80FF_0000);
    idle_cycle();
    check("lb_addr", last_addr, 32'h1000);
    check("lb_stall_cycles", stall_cnt - s0, 3);
    check("lb_wb_data", last_wb_data, 32'hFFFF_FF80);

    run_instr(mk(1, 1, 0, 3'b101, 32'h2002, 0, 5'd8, 1), 1, 32'h8001_1234);
    idle_cycle();
    check("lhu_wb_data", last_wb_data, 32'h0000_8001);

    run_instr(mk(1, 0, 1, 3'b000, 32'h3001, 32'hAB, 5'd9, 1), 2, 0);
    idle_cycle();
    check("sb_be", last_be, 4'b0010);
    check("sb_wdata", last_wdata, 32'hABAB_ABAB);
    check("sb_wben", last_wben, 0);

    r0 = req_cnt; b0 = berr_cnt;
    run_instr(mk(1, 0, 1, 3'b010, 32'h5000, 32'h1, 5'd10, 1), 0, 0);
    idle_cycle();
    check("to_req_cycles", req_cnt - r0, TO);
    check("to_bus_err", berr_cnt - b0, 1);
    check("to_wben", last_wben, 0);

    r0 = req_cnt; m0 = mis_cnt;
    run_instr(mk(1, 1, 0, 3'b010, 32'h4002, 0, 5'd11, 1), 1, 32'hCAFE_F00D);
    idle_cycle();
`ifdef MISALIGN_TRAP_EN
    check("lw_mis_req", req_cnt - r0, 0);
    check("lw_mis_pulse", mis_cnt - m0, 1);
`else
    check("lw_lane0_addr", last_addr, 32'h4000);
    check("lw_lane0_data", last_wb_data, 32'hCAFE_F00D);
    check("lw_no_mis", mis_cnt - m0, 0);
`endif

    for (int k = 0; k < 300; k++) begin
      int d;
      d = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, TO);
      run_instr(rand_instr(), d, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    repeat (3) idle_cycle();

    // Reset while an access is outstanding.
    in = mk(1, 1, 0, 3'b010, 32'h6000, 0, 5'd12, 1);
    c = cyc;
    drive(in, 1'b1);
    for (int i = 1; i <= 2; i++) begin
      e = get_exp(c + i);
      e.stall = 1; e.req = 1; e.addr = 32'h6000; e.we = 0; e.be = 4'hF;
      sched[c + i] = e;
    end
    repeat (3) begin
      next_cycle();
      drive(rand_instr(), 1'b0);
    end
    check("pre_rst_req", dmem_req, 1);
    w0 = wb_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", dmem_req, 0);
    check("rst_stall_drop", stall_out, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    repeat (5) idle_cycle();
    check("rst_no_wb", wb_cnt - w0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
